// File: rtl/aes256_rk_cache.sv
`default_nettype none
// ============================================================================
// Module      : aes256_rk_cache
// Description : Round-key cache for AES-256. Captures the key schedule one
//               round key at a time as the expansion stage produces it, then
//               serves registered single-cycle-latency reads in forward
//               (encryption) or reverse (decryption) round order.
// Revision    : 1.0 - initial release
// ============================================================================
module aes256_rk_cache #(
   parameter int NUM_RK   = 15,
   parameter int RK_WIDTH = 128
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                load_start,
   input  logic                rk_valid,
   input  logic [RK_WIDTH-1:0] rk_in,
   input  logic                rd_en,
   input  logic [3:0]          rd_idx,
   input  logic                rd_rev,
   output logic [RK_WIDTH-1:0] rd_key,
   output logic                rd_valid,
   output logic                rd_err,
   output logic                ready,
   output logic [3:0]          fill_cnt,
   output logic                ovf
);

   typedef enum logic [1:0] {
      S_EMPTY = 2'd0,
      S_FILL  = 2'd1,
      S_READY = 2'd2
   } state_t;

   localparam logic [3:0] LAST_IDX = 4'(NUM_RK - 1);

   state_t              state_q, state_d;
   logic [3:0]          fill_cnt_q, fill_cnt_d;
   logic                ovf_q, ovf_d;
   logic                rd_valid_q, rd_valid_d;
   logic                rd_err_q, rd_err_d;
   logic [RK_WIDTH-1:0] rd_key_q, rd_key_d;

   logic                wr_en;
   logic [3:0]          wr_idx;
   logic [3:0]          rd_sel;

   // Storage is deliberately not reset: nothing reads it until ready is set.
   logic [RK_WIDTH-1:0] mem_q [NUM_RK];

   // Fill sequencing: load_start always wins and restarts the capture; a key
   // arriving outside FILL is dropped and flagged as overflow.
   always_comb begin
      state_d    = state_q;
      fill_cnt_d = fill_cnt_q;
      ovf_d      = ovf_q;
      wr_en      = 1'b0;
      wr_idx     = fill_cnt_q;
      if (load_start) begin
         state_d    = S_FILL;
         fill_cnt_d = 4'd0;
         ovf_d      = 1'b0;
         if (rk_valid) begin
            wr_en      = 1'b1;
            wr_idx     = 4'd0;
            fill_cnt_d = 4'd1;
            if (LAST_IDX == 4'd0) begin
               state_d = S_READY;
            end
         end
      end else if (rk_valid) begin
         if (state_q == S_FILL) begin
            wr_en      = 1'b1;
            fill_cnt_d = fill_cnt_q + 4'd1;
            if (fill_cnt_q == LAST_IDX) begin
               state_d = S_READY;
            end
         end else begin
            ovf_d = 1'b1;
         end
      end
   end

   // Read path: decided on the current state, so a read coinciding with
   // load_start still returns the old schedule.
   always_comb begin
      rd_valid_d = 1'b0;
      rd_err_d   = 1'b0;
      rd_key_d   = rd_key_q;
      rd_sel     = rd_rev ? (LAST_IDX - rd_idx) : rd_idx;
      if (rd_en) begin
         if ((state_q == S_READY) && (rd_idx <= LAST_IDX)) begin
            rd_valid_d = 1'b1;
            rd_key_d   = mem_q[rd_sel];
         end else begin
            rd_err_d = 1'b1;
         end
      end
   end

   // Control and read-output registers with asynchronous active-low reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_EMPTY;
         fill_cnt_q <= 4'd0;
         ovf_q      <= 1'b0;
         rd_valid_q <= 1'b0;
         rd_err_q   <= 1'b0;
         rd_key_q   <= '0;
      end else begin
         state_q    <= state_d;
         fill_cnt_q <= fill_cnt_d;
         ovf_q      <= ovf_d;
         rd_valid_q <= rd_valid_d;
         rd_err_q   <= rd_err_d;
         rd_key_q   <= rd_key_d;
      end
   end

   // Round-key storage write port.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem_q[wr_idx] <= rk_in;
      end
   end

   assign rd_key   = rd_key_q;
   assign rd_valid = rd_valid_q;
   assign rd_err   = rd_err_q;
   assign ready    = (state_q == S_READY);
   assign fill_cnt = fill_cnt_q;
   assign ovf      = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_aes256_rk_cache.sv
`default_nettype none
// ============================================================================
// Module      : tb_aes256_rk_cache
// Description : Directed self-checking bench for aes256_rk_cache.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_aes256_rk_cache;

   logic         clk;
   logic         rst_n;
   logic         load_start;
   logic         rk_valid;
   logic [127:0] rk_in;
   logic         rd_en;
   logic [3:0]   rd_idx;
   logic         rd_rev;
   logic [127:0] rd_key;
   logic         rd_valid;
   logic         rd_err;
   logic         ready;
   logic [3:0]   fill_cnt;
   logic         ovf;

   int checks = 0;
   int errors = 0;

   aes256_rk_cache #(.NUM_RK(15), .RK_WIDTH(128)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .load_start (load_start),
      .rk_valid   (rk_valid),
      .rk_in      (rk_in),
      .rd_en      (rd_en),
      .rd_idx     (rd_idx),
      .rd_rev     (rd_rev),
      .rd_key     (rd_key),
      .rd_valid   (rd_valid),
      .rd_err     (rd_err),
      .ready      (ready),
      .fill_cnt   (fill_cnt),
      .ovf        (ovf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Key patterns: a 32-bit word replicated four times.
   function automatic logic [127:0] key_a(input int i);
      logic [31:0] w;
      w = 32'(i);
      return {w, w, w, w};
   endfunction

   function automatic logic [127:0] key_b(input int i);
      logic [31:0] w;
      w = 32'hA000_0000 + 32'(i);
      return {w, w, w, w};
   endfunction

   function automatic logic [127:0] key_c(input int i);
      logic [31:0] w;
      w = 32'h5C00_0000 + 32'(i);
      return {w, w, w, w};
   endfunction

   // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      load_start = 1'b0;
      rk_valid   = 1'b0;
      rd_en      = 1'b0;
      rd_rev     = 1'b0;
      rd_idx     = 4'd0;
      rk_in      = '0;
   endtask

   task automatic push_key(input logic [127:0] k);
      rk_valid = 1'b1;
      rk_in    = k;
      tick();
      rk_valid = 1'b0;
   endtask

   task automatic start_load();
      load_start = 1'b1;
      tick();
      load_start = 1'b0;
   endtask

   task automatic test_reset();
      idle();
      rst_n = 1'b0;
      tick();
      checks++;
      if (ready !== 1'b0 || fill_cnt !== 4'd0 || ovf !== 1'b0) begin
         errors++;
         $display("FAIL reset_ctrl: ready=%b fill_cnt=%0d ovf=%b, need 0 0 0", ready, fill_cnt, ovf);
      end
      checks++;
      if (rd_valid !== 1'b0 || rd_err !== 1'b0 || rd_key !== 128'd0) begin
         errors++;
         $display("FAIL reset_rd: rd_valid=%b rd_err=%b rd_key=%h, need 0 0 0", rd_valid, rd_err, rd_key);
      end
      rst_n = 1'b1;
      tick();
      // Read while EMPTY is rejected.
      rd_en  = 1'b1;
      rd_idx = 4'd0;
      tick();
      rd_en = 1'b0;
      checks++;
      if (rd_err !== 1'b1 || rd_valid !== 1'b0) begin
         errors++;
         $display("FAIL empty_read: rd_err=%b rd_valid=%b, need 1 0", rd_err, rd_valid);
      end
   endtask

   task automatic test_full_fill();
      start_load();
      checks++;
      if (fill_cnt !== 4'd0 || ready !== 1'b0) begin
         errors++;
         $display("FAIL fill_start: fill_cnt=%0d ready=%b, need 0 0", fill_cnt, ready);
      end
      for (int i = 0; i < 14; i++) push_key(key_a(i));
      checks++;
      if (fill_cnt !== 4'd14 || ready !== 1'b0) begin
         errors++;
         $display("FAIL fill_14: fill_cnt=%0d ready=%b, need 14 0", fill_cnt, ready);
      end
      push_key(key_a(14));
      checks++;
      if (fill_cnt !== 4'd15 || ready !== 1'b1) begin
         errors++;
         $display("FAIL fill_done: fill_cnt=%0d ready=%b, need 15 1", fill_cnt, ready);
      end
      // Back-to-back reads, one per cycle.
      for (int i = 0; i < 15; i++) begin
         rd_en  = 1'b1;
         rd_idx = 4'(i);
         tick();
         checks++;
         if (rd_valid !== 1'b1 || rd_err !== 1'b0 || rd_key !== key_a(i)) begin
            errors++;
            $display("FAIL b2b_read[%0d]: rd_valid=%b rd_err=%b rd_key=%h, need 1 0 %h",
                     i, rd_valid, rd_err, rd_key, key_a(i));
         end
      end
      rd_en = 1'b0;
      tick();
      checks++;
      if (rd_valid !== 1'b0 || rd_key !== key_a(14)) begin
         errors++;
         $display("FAIL read_hold: rd_valid=%b rd_key=%h, need 0 %h", rd_valid, rd_key, key_a(14));
      end
   endtask

   task automatic test_reverse();
      rd_en  = 1'b1;
      rd_rev = 1'b1;
      rd_idx = 4'd0;
      tick();
      checks++;
      if (rd_valid !== 1'b1 || rd_key !== key_a(14)) begin
         errors++;
         $display("FAIL rev_idx0: rd_valid=%b rd_key=%h, need 1 %h", rd_valid, rd_key, key_a(14));
      end
      rd_idx = 4'd14;
      tick();
      checks++;
      if (rd_valid !== 1'b1 || rd_key !== key_a(0)) begin
         errors++;
         $display("FAIL rev_idx14: rd_valid=%b rd_key=%h, need 1 %h", rd_valid, rd_key, key_a(0));
      end
      rd_idx = 4'd4;
      tick();
      checks++;
      if (rd_valid !== 1'b1 || rd_key !== key_a(10)) begin
         errors++;
         $display("FAIL rev_idx4: rd_valid=%b rd_key=%h, need 1 %h", rd_valid, rd_key, key_a(10));
      end
      idle();
      tick();
   endtask

   task automatic test_reject_ready();
      rd_en  = 1'b1;
      rd_idx = 4'd15;
      tick();
      rd_en = 1'b0;
      checks++;
      if (rd_err !== 1'b1 || rd_valid !== 1'b0 || rd_key !== key_a(10)) begin
         errors++;
         $display("FAIL reject_idx15: rd_err=%b rd_valid=%b rd_key=%h, need 1 0 %h",
                  rd_err, rd_valid, rd_key, key_a(10));
      end
      tick();
      checks++;
      if (rd_err !== 1'b0) begin
         errors++;
         $display("FAIL err_pulse: rd_err=%b, need 0", rd_err);
      end
   endtask

   task automatic test_load_read_overlap();
      load_start = 1'b1;
      rd_en      = 1'b1;
      rd_idx     = 4'd3;
      tick();
      load_start = 1'b0;
      checks++;
      if (rd_valid !== 1'b1 || rd_key !== key_a(3) || ready !== 1'b0 || fill_cnt !== 4'd0) begin
         errors++;
         $display("FAIL overlap_read: rd_valid=%b rd_key=%h ready=%b fill_cnt=%0d, need 1 %h 0 0",
                  rd_valid, rd_key, ready, fill_cnt, key_a(3));
      end
      tick();
      rd_en = 1'b0;
      checks++;
      if (rd_err !== 1'b1 || rd_valid !== 1'b0 || rd_key !== key_a(3)) begin
         errors++;
         $display("FAIL overlap_after: rd_err=%b rd_valid=%b rd_key=%h, need 1 0 %h",
                  rd_err, rd_valid, rd_key, key_a(3));
      end
   endtask

   task automatic test_reject_fill();
      start_load();
      for (int i = 0; i < 7; i++) push_key(key_c(i));
      rd_en  = 1'b1;
      rd_idx = 4'd2;
      tick();
      rd_en = 1'b0;
      checks++;
      if (fill_cnt !== 4'd7 || rd_err !== 1'b1 || rd_valid !== 1'b0) begin
         errors++;
         $display("FAIL fill_read: fill_cnt=%0d rd_err=%b rd_valid=%b, need 7 1 0",
                  fill_cnt, rd_err, rd_valid);
      end
   endtask

   task automatic test_gaps_overflow();
      start_load();
      for (int i = 0; i < 15; i++) begin
         push_key(key_b(i));
         for (int g = 0; g < ((i * 7 + 3) % 6); g++) tick();
      end
      checks++;
      if (ready !== 1'b1 || fill_cnt !== 4'd15 || ovf !== 1'b0) begin
         errors++;
         $display("FAIL gap_fill: ready=%b fill_cnt=%0d ovf=%b, need 1 15 0", ready, fill_cnt, ovf);
      end
      for (int i = 0; i < 15; i++) begin
         rd_en  = 1'b1;
         rd_idx = 4'(i);
         tick();
         checks++;
         if (rd_valid !== 1'b1 || rd_key !== key_b(i)) begin
            errors++;
            $display("FAIL gap_read[%0d]: rd_valid=%b rd_key=%h, need 1 %h", i, rd_valid, rd_key, key_b(i));
         end
      end
      rd_en = 1'b0;
      push_key(128'hDEAD_BEEF_DEAD_BEEF_DEAD_BEEF_DEAD_BEEF);
      checks++;
      if (ovf !== 1'b1 || ready !== 1'b1 || fill_cnt !== 4'd15) begin
         errors++;
         $display("FAIL ovf_set: ovf=%b ready=%b fill_cnt=%0d, need 1 1 15", ovf, ready, fill_cnt);
      end
      rd_en  = 1'b1;
      rd_idx = 4'd0;
      tick();
      rd_en = 1'b0;
      checks++;
      if (rd_key !== key_b(0) || ovf !== 1'b1) begin
         errors++;
         $display("FAIL ovf_entry0: rd_key=%h ovf=%b, need %h 1", rd_key, ovf, key_b(0));
      end
      start_load();
      checks++;
      if (ovf !== 1'b0) begin
         errors++;
         $display("FAIL ovf_clear: ovf=%b, need 0", ovf);
      end
   endtask

   task automatic test_restart();
      start_load();
      for (int i = 0; i < 9; i++) push_key(key_a(i + 100));
      load_start = 1'b1;
      push_key(key_c(50));
      load_start = 1'b0;
      checks++;
      if (fill_cnt !== 4'd1 || ready !== 1'b0) begin
         errors++;
         $display("FAIL restart_cnt: fill_cnt=%0d ready=%b, need 1 0", fill_cnt, ready);
      end
      for (int i = 1; i < 15; i++) push_key(key_c(50 + i));
      checks++;
      if (ready !== 1'b1) begin
         errors++;
         $display("FAIL restart_ready: ready=%b, need 1", ready);
      end
      rd_en  = 1'b1;
      rd_idx = 4'd0;
      tick();
      rd_en = 1'b0;
      checks++;
      if (rd_valid !== 1'b1 || rd_key !== key_c(50)) begin
         errors++;
         $display("FAIL restart_entry0: rd_valid=%b rd_key=%h, need 1 %h", rd_valid, rd_key, key_c(50));
      end
   endtask

   task automatic test_async_reset();
      start_load();
      for (int i = 0; i < 5; i++) push_key(key_b(i + 20));
      rd_en  = 1'b1;
      rd_idx = 4'd1;
      #3;
      rst_n = 1'b0;
      #1;
      checks++;
      if (ready !== 1'b0 || fill_cnt !== 4'd0 || ovf !== 1'b0 ||
          rd_valid !== 1'b0 || rd_err !== 1'b0 || rd_key !== 128'd0) begin
         errors++;
         $display("FAIL async_reset: ready=%b fill_cnt=%0d ovf=%b rd_valid=%b rd_err=%b rd_key=%h, need all 0",
                  ready, fill_cnt, ovf, rd_valid, rd_err, rd_key);
      end
      idle();
      #2;
      rst_n = 1'b1;
      tick();
      checks++;
      if (ready !== 1'b0 || fill_cnt !== 4'd0) begin
         errors++;
         $display("FAIL post_reset: ready=%b fill_cnt=%0d, need 0 0", ready, fill_cnt);
      end
      start_load();
      for (int i = 0; i < 15; i++) push_key(key_a(200 + i));
      checks++;
      if (ready !== 1'b1 || fill_cnt !== 4'd15) begin
         errors++;
         $display("FAIL refill_ready: ready=%b fill_cnt=%0d, need 1 15", ready, fill_cnt);
      end
      rd_en  = 1'b1;
      rd_idx = 4'd5;
      tick();
      rd_en = 1'b0;
      checks++;
      if (rd_valid !== 1'b1 || rd_key !== key_a(205)) begin
         errors++;
         $display("FAIL refill_read: rd_valid=%b rd_key=%h, need 1 %h", rd_valid, rd_key, key_a(205));
      end
   endtask

   initial begin
      rst_n = 1'b0;
      idle();
      test_reset();
      test_full_fill();
      test_reverse();
      test_reject_ready();
      test_load_read_overlap();
      test_reject_fill();
      test_gaps_overflow();
      test_restart();
      test_async_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
